// File: rtl/synth_osc.sv
// rtl/synth_osc.sv - phase-accumulator oscillator with saw/square/triangle/noise output
module synth_osc #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic             Sys_clk,
  input  logic             Syn_rst,
  input  logic             Syn_ce,
  input  logic             Syn_clk,
  input  logic [ACC_W-1:0] Inc_data,
  input  logic             Inc_wr,
  input  logic [1:0]       Wave_sel,
  input  logic [15:0]      Pulse_w,
  input  logic             Hard_sync,
  output logic [OUT_W-1:0] Sample,
  output logic             Sample_valid,
  output logic             Wrap
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // stage 0 / stage 1 state
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sync_q, sync_d;
  logic             wrap_q, wrap_d;
  logic             v1_q, v1_d;
  logic [15:0]      lfsr_q, lfsr_d;

  // stage 2 state
  logic [OUT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;

  logic             tick;
  logic [ACC_W:0]   sum;
  logic [15:0]      p;
  logic [15:0]      tri_t;
  logic [OUT_W-1:0] wave;

  // Tick handling: increment transfer, accumulate or hard sync, LFSR advance
  always_comb begin
    tick     = Syn_clk & Syn_ce;
    // a same-cycle write bypasses the shadow so the tick sees the new value
    shadow_d = Inc_wr ? Inc_data : shadow_q;
    inc_d    = tick ? shadow_d : inc_q;
    sum      = {1'b0, acc_q} + {1'b0, inc_d};
    acc_d    = acc_q;
    wrap_d   = 1'b0;
    sync_d   = sync_q | Hard_sync;
    lfsr_d   = lfsr_q;
    v1_d     = tick;
    if (tick) begin
      sync_d = 1'b0;
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      if (Hard_sync || sync_q) begin
        acc_d = '0;
      end else begin
        acc_d  = sum[ACC_W-1:0];
        wrap_d = sum[ACC_W];
      end
    end
  end

  // Waveform shaping from the stage-1 phase, with selects sampled now
  always_comb begin
    p     = acc_q[ACC_W-1 -: 16];
    tri_t = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
    case (Wave_sel)
      2'd0:    wave = {~p[15], p[14:0]};
      2'd1:    wave = (p < Pulse_w) ? 16'h7FFF : 16'h8000;
      2'd2:    wave = {~tri_t[15], tri_t[14:0]};
      default: wave = lfsr_q;
    endcase
    sample_d = v1_q ? wave : sample_q;
    valid_d  = v1_q;
  end

  // State registers with asynchronous reset
  always_ff @(posedge Sys_clk or posedge Syn_rst) begin
    if (Syn_rst) begin
      shadow_q <= '0;
      inc_q    <= '0;
      acc_q    <= '0;
      sync_q   <= 1'b0;
      wrap_q   <= 1'b0;
      v1_q     <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      inc_q    <= inc_d;
      acc_q    <= acc_d;
      sync_q   <= sync_d;
      wrap_q   <= wrap_d;
      v1_q     <= v1_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign Sample       = sample_q;
  assign Sample_valid = valid_q;
  assign Wrap         = wrap_q;

endmodule

// File: tb/tb_synth_osc.sv
// tb/tb_synth_osc.sv - scoreboard testbench for synth_osc
module tb_synth_osc;

  logic        Sys_clk = 1'b0;
  logic        Syn_rst = 1'b0;
  logic        Syn_ce = 1'b0;
  logic        Syn_clk = 1'b0;
  logic [23:0] Inc_data = '0;
  logic        Inc_wr = 1'b0;
  logic [1:0]  Wave_sel = '0;
  logic [15:0] Pulse_w = '0;
  logic        Hard_sync = 1'b0;
  logic [15:0] Sample;
  logic        Sample_valid;
  logic        Wrap;

  synth_osc #(.ACC_W(24), .OUT_W(16)) dut (
    .Sys_clk(Sys_clk), .Syn_rst(Syn_rst), .Syn_ce(Syn_ce), .Syn_clk(Syn_clk),
    .Inc_data(Inc_data), .Inc_wr(Inc_wr), .Wave_sel(Wave_sel), .Pulse_w(Pulse_w),
    .Hard_sync(Hard_sync), .Sample(Sample), .Sample_valid(Sample_valid), .Wrap(Wrap)
  );

  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    logic [15:0] s;
    logic        w;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  logic        cur_ce = 1'b0;
  logic        wrap_prev = 1'b0;

  // reference model state
  logic [23:0] m_acc;
  logic [23:0] m_shadow;
  logic        m_pend;
  logic [15:0] m_lfsr;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    int unsigned v = x;
    int unsigned b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [15:0] wave_of(logic [23:0] a, logic [15:0] l, logic [1:0] s, logic [15:0] pw);
    int unsigned p = a >> 8;
    int unsigned t;
    case (s)
      2'd0: return 16'(p ^ 32'h8000);
      2'd1: return (p < pw) ? 16'h7FFF : 16'h8000;
      2'd2: begin
        t = (2 * p) % 65536;
        if (p >= 32768) t = 65535 - t;
        return 16'(t ^ 32'h8000);
      end
      default: return l;
    endcase
  endfunction

  // One Sys_clk cycle of stimulus; the model predicts that edge's outcome
  task automatic cycle(bit tk, bit ce, bit wr, logic [23:0] d, bit hs);
    logic [24:0] sum;
    logic [23:0] inc;
    logic        w;
    if (tk && ce) begin
      inc = wr ? d : m_shadow;
      m_lfsr = lfsr_next(m_lfsr);
      w = 1'b0;
      if (hs || m_pend) begin
        m_acc = '0;
      end else begin
        sum = {1'b0, m_acc} + {1'b0, inc};
        w = sum[24];
        m_acc = sum[23:0];
      end
      m_pend = 1'b0;
      q.push_back('{s: wave_of(m_acc, m_lfsr, Wave_sel, Pulse_w), w: w});
    end else begin
      m_pend = m_pend | hs;
    end
    if (wr) m_shadow = d;
    cur_ce = ce;
    Syn_clk = tk; Syn_ce = ce; Inc_wr = wr; Inc_data = d; Hard_sync = hs;
    @(posedge Sys_clk);
    #1;
    Syn_clk = 1'b0; Inc_wr = 1'b0; Hard_sync = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, cur_ce, 0, '0, 0);
  endtask

  task automatic tick_every10(int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 1, 0, '0, 0);
      idle(9);
    end
  endtask

  // Tick, then look at the stage-2 output one cycle later
  task automatic tick_expect(string name, logic [15:0] exp);
    cycle(1, 1, 0, '0, 0);
    idle(1);
    check({name, "_valid"}, Sample_valid, 1);
    check(name, Sample, exp);
    idle(2);
  endtask

  task automatic do_reset();
    Syn_rst = 1'b1;
    #1;
    check("rst_sample", Sample, 16'h0000);
    check("rst_valid", Sample_valid, 0);
    check("rst_wrap", Wrap, 0);
    q.delete();
    m_acc = '0; m_shadow = '0; m_pend = 1'b0; m_lfsr = 16'hACE1;
    @(posedge Sys_clk);
    @(posedge Sys_clk);
    #1;
    Syn_rst = 1'b0;
  endtask

  // Monitor: every Sample_valid pops one expectation; Wrap belongs to the cycle before
  always @(negedge Sys_clk) begin
    exp_t e;
    if (Syn_rst) begin
      wrap_prev = 1'b0;
    end else begin
      if (Sample_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("sample", Sample, e.s);
          check("wrap", wrap_prev, e.w);
        end
      end else if (wrap_prev) begin
        check("orphan_wrap", 1, 0);
      end
      wrap_prev = Wrap;
    end
  end

  initial begin
    m_acc = '0; m_shadow = '0; m_pend = 1'b0; m_lfsr = 16'hACE1;
    #2;
    do_reset();

    // basic saw, with first-sample latency checked explicitly
    Wave_sel = 2'd0;
    cycle(0, 1, 1, 24'h100000, 0);
    idle(9);
    cycle(1, 1, 0, '0, 0);
    @(negedge Sys_clk);
    check("lat_stage1_valid", Sample_valid, 0);
    @(negedge Sys_clk);
    check("lat_stage2_valid", Sample_valid, 1);
    check("first_saw", Sample, 16'h9000);
    idle(8);
    tick_every10(14);
    tick_expect("saw_after_wrap", 16'h8000);

    // hard sync latched 3 cycles before a tick at acc=0x500000
    tick_every10(5);
    idle(6);
    cycle(0, 1, 0, '0, 1);
    idle(2);
    tick_expect("hard_sync_saw", 16'h8000);

    // square threshold at 0x700000 / 0x800000
    do_reset();
    Wave_sel = 2'd1; Pulse_w = 16'h8000;
    cycle(0, 1, 1, 24'h100000, 0);
    tick_every10(6);
    tick_expect("square_below", 16'h7FFF);
    tick_expect("square_at", 16'h8000);

    // triangle peak at 0x800000
    do_reset();
    Wave_sel = 2'd2;
    cycle(0, 1, 1, 24'h100000, 0);
    tick_every10(7);
    tick_expect("tri_peak", 16'h7FFF);

    // back-to-back ticks, plus increment written between ticks
    Wave_sel = 2'd0;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, '0, 0);
    cycle(0, 1, 1, 24'h200000, 0);
    cycle(1, 1, 0, '0, 0);
    cycle(1, 1, 1, 24'h030000, 0);
    idle(4);

    // randomized ticks, enables, writes and syncs
    for (int b = 0; b < 4; b++) begin
      idle(3);
      Wave_sel = 2'($urandom_range(0, 3));
      Pulse_w  = 16'($urandom);
      for (int i = 0; i < 100; i++)
        cycle(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
              24'($urandom), ($urandom % 17) == 0);
    end
    idle(3);

    // noise with enable held low for 5 ticks
    do_reset();
    Wave_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, '0, 0);
      idle(3);
    end
    tick_expect("noise_first", 16'h5670);

    // reset one cycle after a tick discards it and reseeds the LFSR
    cycle(1, 1, 0, '0, 0);
    do_reset();
    idle(3);
    tick_expect("noise_after_rst", 16'h5670);

    idle(5);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
